// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: redirect/stall controls in, instruction-memory port, IF/ID register out.
// Latency: none (pure signal grouping).
// Backpressure: stall is carried here; the fetch unit holds all IF/ID state while it is high.
//
// slave  : view taken by fetch_pc_unit (drives imem_addr and ifid_*).
// master : view taken by the surrounding pipeline / memory (drives controls and imem_data).
interface fetch_pc_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
);
  logic               stall;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] ifid_instr;
  logic [INSTR_W-1:0] ifid_imm;
  logic [PC_W-1:0]    ifid_pc_next;
  logic               ifid_valid;

  modport slave (
    input  stall, br_taken, br_target, imem_data,
    output imem_addr, ifid_instr, ifid_imm, ifid_pc_next, ifid_valid
  );

  modport master (
    output stall, br_taken, br_target, imem_data,
    input  imem_addr, ifid_instr, ifid_imm, ifid_pc_next, ifid_valid
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, reset-vector load, one/two-word instruction assembly into IF/ID.
// Latency: one-word instr in IF/ID 1 cycle after address issue; two-word after 2 (one bubble).
// Backpressure: stall freezes PC/state/IF/ID; br_taken redirects and overrides stall.
//
// Ports: clk, rst (async active-low), bus (fetch_pc_unit_if.slave):
//   in : stall, br_taken, br_target, imem_data (asynchronous read of imem_addr)
//   out: imem_addr (combinational), ifid_instr, ifid_imm, ifid_pc_next, ifid_valid
module fetch_pc_unit #(
  parameter int               PC_W           = 32,
  parameter int               INSTR_W        = 16,
  parameter logic [PC_W-1:0]  RESET_VEC_ADDR = '0,
  parameter int               IMM_BIT        = 15
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {VEC_HI, VEC_LO, FETCH, FETCH_IMM} state_e;

  state_e               state_q;
  logic [PC_W-1:0]      pc_q;
  logic [INSTR_W-1:0]   vec_hi_q;
  logic [INSTR_W-1:0]   op_buf_q;
  logic [INSTR_W-1:0]   ifid_instr_q;
  logic [INSTR_W-1:0]   ifid_imm_q;
  logic [PC_W-1:0]      ifid_pc_next_q;
  logic                 ifid_valid_q;

  logic [PC_W-1:0]      pc_inc_d;
  logic [2*INSTR_W-1:0] vec_full_d;

  // Wraps silently at the top of the address space.
  assign pc_inc_d   = pc_q + PC_W'(1);
  assign vec_full_d = {vec_hi_q, bus.imem_data};

  always_comb begin
    bus.imem_addr = pc_q;
    case (state_q)
      VEC_HI:  bus.imem_addr = RESET_VEC_ADDR;
      VEC_LO:  bus.imem_addr = RESET_VEC_ADDR + PC_W'(1);
      default: bus.imem_addr = pc_q;
    endcase
  end

  assign bus.ifid_instr   = ifid_instr_q;
  assign bus.ifid_imm     = ifid_imm_q;
  assign bus.ifid_pc_next = ifid_pc_next_q;
  assign bus.ifid_valid   = ifid_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= VEC_HI;
      pc_q           <= '0;
      vec_hi_q       <= '0;
      op_buf_q       <= '0;
      ifid_instr_q   <= '0;
      ifid_imm_q     <= '0;
      ifid_pc_next_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        // Vector load ignores stall and redirects; IF/ID stays a bubble.
        VEC_HI: begin
          vec_hi_q <= bus.imem_data;
          state_q  <= VEC_LO;
        end
        VEC_LO: begin
          pc_q    <= PC_W'(vec_full_d);
          state_q <= FETCH;
        end
        default: begin
          if (bus.br_taken) begin
            // Redirect wins over stall; any half-assembled op_buf is abandoned
            // simply by returning to FETCH. ifid data fields may go stale.
            pc_q         <= bus.br_target;
            state_q      <= FETCH;
            ifid_valid_q <= 1'b0;
          end else if (!bus.stall) begin
            pc_q <= pc_inc_d;
            if (state_q == FETCH) begin
              if (bus.imem_data[IMM_BIT]) begin
                op_buf_q     <= bus.imem_data;
                ifid_valid_q <= 1'b0;
                state_q      <= FETCH_IMM;
              end else begin
                ifid_instr_q   <= bus.imem_data;
                ifid_imm_q     <= '0;
                ifid_pc_next_q <= pc_inc_d;
                ifid_valid_q   <= 1'b1;
              end
            end else begin
              ifid_instr_q   <= op_buf_q;
              ifid_imm_q     <= bus.imem_data;
              ifid_pc_next_q <= pc_inc_d;
              ifid_valid_q   <= 1'b1;
              state_q        <= FETCH;
            end
          end
        end
      endcase
    end
  end

endmodule
